pc_fetch_gen: RTL and testbench

//   IF-stage PC generator; sits directly upstream of the instruction ROM.

---
 rtl/pc_fetch_gen_if.sv | 31 +++
 rtl/pc_fetch_gen.sv | 96 +++++++++
 tb/tb_pc_fetch_gen.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_gen_if.sv
// Pipeline-control <-> IF-stage PC generator bundle.
// IF_ALIGN_CHECK_EN adds the instruction-address-error flag if_adel_o.
interface pc_fetch_gen_if;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] new_pc_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic [31:0] pc_o;
  logic        ce_o;
  logic        br_pending_o;
`ifdef IF_ALIGN_CHECK_EN
  logic        if_adel_o;
`endif

  modport master (
    output stall_i, flush_i, new_pc_i, branch_flag_i, branch_target_i,
`ifdef IF_ALIGN_CHECK_EN
    input  if_adel_o,
`endif
    input  pc_o, ce_o, br_pending_o
  );

  modport slave (
    input  stall_i, flush_i, new_pc_i, branch_flag_i, branch_target_i,
`ifdef IF_ALIGN_CHECK_EN
    output if_adel_o,
`endif
    output pc_o, ce_o, br_pending_o
  );
endinterface

// File: rtl/pc_fetch_gen.sv
// IF-stage PC generator: sequential fetch, branch/flush redirects, stall with held branch.
// Optional IF_ALIGN_CHECK_EN: flag misaligned fetch on if_adel_o instead of forcing alignment.
module pc_fetch_gen #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic           clk,
  input  logic           rst_n,
  pc_fetch_gen_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, HOLD_BR} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic        ce_q, ce_d;
  logic        br_pend_q, br_pend_d;
  logic        frozen;

`ifdef IF_ALIGN_CHECK_EN
  localparam logic [31:0] TGT_MASK = 32'hFFFF_FFFF;
  logic adel_q, adel_d;
  // A misaligned pc parks the fetch until an exception redirect arrives.
  assign frozen = adel_q;
`else
  localparam logic [31:0] TGT_MASK = 32'hFFFF_FFFC;
  assign frozen = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_tgt_d = pend_tgt_q;
    if (state_q == IDLE) begin
      state_d = RUN;
    end else if (bus.flush_i) begin
      pc_d    = bus.new_pc_i & TGT_MASK;
      state_d = RUN;
    end else if (frozen) begin
      state_d = state_q;
    end else if (bus.stall_i && bus.branch_flag_i) begin
      pend_tgt_d = bus.branch_target_i & TGT_MASK;
      state_d    = HOLD_BR;
    end else if (bus.stall_i) begin
      state_d = (state_q == HOLD_BR) ? HOLD_BR : HOLD;
    end else if (bus.branch_flag_i) begin
      pc_d    = bus.branch_target_i & TGT_MASK;
      state_d = RUN;
    end else if (state_q == HOLD_BR) begin
      pc_d    = pend_tgt_q;
      state_d = RUN;
    end else begin
      pc_d    = pc_q + PC_STEP;
      state_d = RUN;
    end

    br_pend_d = (state_d == HOLD_BR);
`ifdef IF_ALIGN_CHECK_EN
    adel_d = (state_d != IDLE) && (pc_d[1:0] != 2'b00);
    ce_d   = (state_d != IDLE) && (pc_d[1:0] == 2'b00);
`else
    ce_d   = (state_d != IDLE);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      pend_tgt_q <= 32'h0;
      ce_q       <= 1'b0;
      br_pend_q  <= 1'b0;
`ifdef IF_ALIGN_CHECK_EN
      adel_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_tgt_q <= pend_tgt_d;
      ce_q       <= ce_d;
      br_pend_q  <= br_pend_d;
`ifdef IF_ALIGN_CHECK_EN
      adel_q     <= adel_d;
`endif
    end
  end

  assign bus.pc_o         = pc_q;
  assign bus.ce_o         = ce_q;
  assign bus.br_pending_o = br_pend_q;
`ifdef IF_ALIGN_CHECK_EN
  assign bus.if_adel_o    = adel_q;
`endif

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Self-checking bench for pc_fetch_gen: directed scenarios plus randomized traffic
// compared against a flag-based reference model of the fetch rules.
module tb_pc_fetch_gen;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

`ifdef IF_ALIGN_CHECK_EN
  localparam logic [31:0] MODEL_MASK = 32'hFFFF_FFFF;
  localparam logic [31:0] RAND_MASK  = 32'hFFFF_FFFC;
`else
  localparam logic [31:0] MODEL_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] RAND_MASK  = 32'hFFFF_FFFF;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  pc_fetch_gen_if bus ();

  pc_fetch_gen #(.RESET_PC(RESET_PC), .PC_STEP(32'd4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: "started" replaces IDLE, "pending" replaces HOLD_BR.
  bit          m_run;
  bit          m_pend;
  logic [31:0] m_pc;
  logic [31:0] m_tgt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run  = 1'b0;
    m_pend = 1'b0;
    m_pc   = RESET_PC;
    m_tgt  = 32'h0;
  endtask

  task automatic model_edge();
    if (!m_run) begin
      m_run = 1'b1;
    end else if (bus.flush_i) begin
      m_pc   = bus.new_pc_i & MODEL_MASK;
      m_pend = 1'b0;
    end else if (bus.stall_i && bus.branch_flag_i) begin
      m_pend = 1'b1;
      m_tgt  = bus.branch_target_i & MODEL_MASK;
    end else if (bus.stall_i) begin
      m_pend = m_pend;
    end else if (bus.branch_flag_i) begin
      m_pc   = bus.branch_target_i & MODEL_MASK;
      m_pend = 1'b0;
    end else if (m_pend) begin
      m_pc   = m_tgt;
      m_pend = 1'b0;
    end else begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic drive(input logic st, input logic fl, input logic [31:0] npc,
                       input logic br, input logic [31:0] bt);
    bus.stall_i         = st;
    bus.flush_i         = fl;
    bus.new_pc_i        = npc;
    bus.branch_flag_i   = br;
    bus.branch_target_i = bt;
  endtask

  task automatic compare_model(input string tag);
    chk({tag, ".pc"},  bus.pc_o, m_pc);
    chk({tag, ".ce"},  {31'b0, bus.ce_o}, {31'b0, m_run});
    chk({tag, ".brp"}, {31'b0, bus.br_pending_o}, {31'b0, m_pend});
  endtask

  // One clock edge: model follows the inputs the DUT sees, outputs checked on the falling edge.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_model(tag);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset.pc",  bus.pc_o, RESET_PC);
    chk("reset.ce",  {31'b0, bus.ce_o}, 32'h0);
    chk("reset.brp", {31'b0, bus.br_pending_o}, 32'h0);

    // Reset release: first fetch is RESET_PC, then sequential.
    rst_n = 1'b1;
    step("rel0");
    chk("rel0.pc_const", bus.pc_o, 32'h0);
    chk("rel0.ce_const", {31'b0, bus.ce_o}, 32'h1);
    step("seq4");
    chk("seq4.pc_const", bus.pc_o, 32'h4);
    step("seq8");
    chk("seq8.pc_const", bus.pc_o, 32'h8);

    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h100);
    step("br100");
    chk("br100.pc_const", bus.pc_o, 32'h100);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step("br104");
    chk("br104.pc_const", bus.pc_o, 32'h104);

    // Three-cycle stall, branch on the second stall cycle.
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step("stall1");
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h200);
    step("stall2");
    chk("stall2.brp_const", {31'b0, bus.br_pending_o}, 32'h1);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step("stall3");
    chk("stall3.pc_const", bus.pc_o, 32'h104);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step("unstall");
    chk("unstall.pc_const", bus.pc_o, 32'h200);
    chk("unstall.brp_const", {31'b0, bus.br_pending_o}, 32'h0);

    // Flush beats stall and a pending branch.
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h300);
    step("pend300");
    drive(1'b1, 1'b1, 32'h20, 1'b0, 32'h0);
    step("flush20");
    chk("flush20.pc_const", bus.pc_o, 32'h20);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step("flush_run");
    chk("flush_run.pc_const", bus.pc_o, 32'h24);

    // 32-bit wrap.
    drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    step("wrap_load");
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step("wrap");
    chk("wrap.pc_const", bus.pc_o, 32'h0);

`ifdef IF_ALIGN_CHECK_EN
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h102);
    @(posedge clk);
    @(negedge clk);
    chk("misalign.adel", {31'b0, bus.if_adel_o}, 32'h1);
    chk("misalign.ce",   {31'b0, bus.ce_o}, 32'h0);
    chk("misalign.pc",   bus.pc_o, 32'h102);
    drive(1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("adel_exit.adel", {31'b0, bus.if_adel_o}, 32'h0);
    chk("adel_exit.pc",   bus.pc_o, 32'h40);
    m_pc = 32'h40;
    m_pend = 1'b0;
`else
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h102);
    step("misalign");
    chk("misalign.pc_const", bus.pc_o, 32'h100);
    chk("misalign.ce_const", {31'b0, bus.ce_o}, 32'h1);
`endif

    // Randomized traffic with occasional asynchronous reset.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        drive($urandom_range(0, 1) == 1, 1'b0, 32'h0, $urandom_range(0, 1) == 1, $urandom & RAND_MASK);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_model("rand_rst");
        @(negedge clk);
        rst_n = 1'b1;
      end
      drive($urandom_range(0, 99) < 40,
            $urandom_range(0, 99) < 8,
            $urandom & RAND_MASK,
            $urandom_range(0, 99) < 25,
            $urandom & RAND_MASK);
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
